// File: rtl/wyszukiwanie_pkg.sv
// Shared types and defaults for the lowest-set-bit scanner.
package wyszukiwanie_pkg;

   localparam int unsigned BITS_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : wyszukiwanie_pkg

// File: rtl/wyszukiwanie_bitu.sv
// Sequential lowest-set-bit finder: tests one operand bit per cycle, LSB first,
// then publishes the index, the operand with that bit cleared, and a zero flag.
module wyszukiwanie_bitu
   import wyszukiwanie_pkg::*;
#(
   parameter  int unsigned BITS  = BITS_DEF,
   localparam int unsigned IDX_W = $clog2(BITS)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [BITS-1:0]  i_argA,
   output logic             o_busy,
   output logic             o_done,
   output logic [IDX_W-1:0] o_index,
   output logic [BITS-1:0]  o_result,
   output logic             o_error
);

   state_e             state_q, state_d;
   logic [BITS-1:0]    opnd_q, opnd_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_pend_q, idx_pend_d;
   logic [BITS-1:0]    res_pend_q, res_pend_d;
   logic               err_pend_q, err_pend_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [IDX_W-1:0]   index_q, index_d;
   logic [BITS-1:0]    result_q, result_d;
   logic               error_q, error_d;

   // Results are staged while in DONE and published together with o_done,
   // so visible outputs change only on the o_done cycle.
   always_comb begin
      state_d    = state_q;
      opnd_d     = opnd_q;
      cnt_d      = cnt_q;
      idx_pend_d = idx_pend_q;
      res_pend_d = res_pend_q;
      err_pend_d = err_pend_q;
      done_d     = 1'b0;
      index_d    = index_q;
      result_d   = result_q;
      error_d    = error_q;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               opnd_d  = i_argA;
               cnt_d   = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (opnd_q[cnt_q]) begin
               idx_pend_d = cnt_q;
               res_pend_d = opnd_q & ~(BITS'(1) << cnt_q);
               err_pend_d = 1'b0;
               state_d    = DONE;
            end else if (cnt_q == IDX_W'(BITS - 1)) begin
               idx_pend_d = '0;
               res_pend_d = '0;
               err_pend_d = 1'b1;
               state_d    = DONE;
            end else begin
               cnt_d = cnt_q + IDX_W'(1);
            end
         end
         DONE: begin
            done_d   = 1'b1;
            index_d  = idx_pend_q;
            result_d = res_pend_q;
            error_d  = err_pend_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         opnd_q     <= '0;
         cnt_q      <= '0;
         idx_pend_q <= '0;
         res_pend_q <= '0;
         err_pend_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         index_q    <= '0;
         result_q   <= '0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         opnd_q     <= opnd_d;
         cnt_q      <= cnt_d;
         idx_pend_q <= idx_pend_d;
         res_pend_q <= res_pend_d;
         err_pend_q <= err_pend_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         index_q    <= index_d;
         result_q   <= result_d;
         error_q    <= error_d;
      end
   end

   assign o_busy   = busy_q;
   assign o_done   = done_q;
   assign o_index  = index_q;
   assign o_result = result_q;
   assign o_error  = error_q;

endmodule : wyszukiwanie_bitu

// File: tb/tb_wyszukiwanie_bitu.sv
// Randomized self-checking bench for wyszukiwanie_bitu against a
// find-first-set reference model.
module tb_wyszukiwanie_bitu;

   localparam int unsigned BITS  = 32;
   localparam int unsigned IDX_W = 5;

   logic             clk;
   logic             i_rst;
   logic             i_start;
   logic [BITS-1:0]  i_argA;
   logic             o_busy;
   logic             o_done;
   logic [IDX_W-1:0] o_index;
   logic [BITS-1:0]  o_result;
   logic             o_error;

   int n_chk = 0;
   int n_err = 0;

   wyszukiwanie_bitu #(.BITS(BITS)) dut (
      .i_clk    (clk),
      .i_rst    (i_rst),
      .i_start  (i_start),
      .i_argA   (i_argA),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_index  (o_index),
      .o_result (o_result),
      .o_error  (o_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_busy"},   64'(o_busy),   64'd0);
      chk({tag, "_done"},   64'(o_done),   64'd0);
      chk({tag, "_index"},  64'(o_index),  64'd0);
      chk({tag, "_result"}, 64'(o_result), 64'd0);
      chk({tag, "_error"},  64'(o_error),  64'd0);
   endtask

   // mode 0: quiet, 1: random i_argA/i_start noise while busy,
   // 2: second start with operand 1 two cycles after the first
   task automatic run_op(input logic [31:0] arg, input int mode, input string tag);
      int          k;
      int          lat;
      int          exp_lat;
      bit          seen;
      logic [31:0] exp_res;
      logic        exp_err;

      exp_err = (arg == 32'd0);
      k = 0;
      if (!exp_err)
         while (k < 31 && arg[k] == 1'b0) k++;
      exp_res = exp_err ? 32'd0 : (arg & ~(32'd1 << k));
      exp_lat = exp_err ? (BITS + 1) : (k + 2);
      if (exp_err) k = 0;

      @(negedge clk);
      i_argA  = arg;
      i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
      chk({tag, "_busy"}, 64'(o_busy), 64'd1);

      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 100) begin
         if (mode == 1) begin
            i_argA  = $urandom;
            i_start = 1'($urandom_range(0, 1));
         end else if (mode == 2) begin
            i_start = (lat == 1);
            if (lat == 1) i_argA = 32'd1;
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
         i_start = 1'b0;
         seen = o_done;
      end

      chk({tag, "_lat"},    64'(lat),      64'(exp_lat));
      chk({tag, "_index"},  64'(o_index),  64'(k));
      chk({tag, "_result"}, 64'(o_result), 64'(exp_res));
      chk({tag, "_error"},  64'(o_error),  64'(exp_err));
      chk({tag, "_busyd"},  64'(o_busy),   64'd0);

      @(negedge clk);
      chk({tag, "_pulse"},  64'(o_done),   64'd0);
      chk({tag, "_hold"},   64'(o_index),  64'(k));
   endtask

   initial begin
      int dones;
      logic [31:0] a;

      i_rst   = 1'b1;
      i_start = 1'b1;
      i_argA  = 32'hDEAD_BEEF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      i_rst   = 1'b0;
      i_start = 1'b0;
      chk_idle_zero("reset");

      run_op(32'h0000_0001, 0, "lsb0");
      run_op(32'hFFFF_0000, 0, "b16");
      run_op(32'h8000_0000, 0, "msb");
      run_op(32'h0000_0000, 0, "zero");
      run_op(32'h0000_0100, 2, "restart");

      // Held i_start: ignored in DONE, accepted on the o_done cycle.
      @(negedge clk);
      i_argA  = 32'd1;
      i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_argA = 32'd2;
      @(negedge clk);
      @(negedge clk);
      chk("hold_done1", 64'(o_done), 64'd1);
      chk("hold_busy1", 64'(o_busy), 64'd0);
      @(negedge clk);
      i_start = 1'b0;
      chk("hold_busy2", 64'(o_busy), 64'd1);
      chk("hold_done0", 64'(o_done), 64'd0);
      @(negedge clk);
      @(negedge clk);
      chk("hold_early", 64'(o_done), 64'd0);
      @(negedge clk);
      chk("hold_done2", 64'(o_done),   64'd1);
      chk("hold_idx2",  64'(o_index),  64'd1);
      chk("hold_res2",  64'(o_result), 64'd0);

      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0:       a = 32'd1 << $urandom_range(0, 31);
            1:       a = (i % 7 == 0) ? 32'd0 : $urandom & ($urandom | 32'hFFFF_0000);
            default: a = $urandom;
         endcase
         run_op(a, 1, "rand");
      end

      // Abort mid-scan; previous run left outputs nonzero.
      run_op(32'h0000_0030, 0, "pre_abort");
      @(negedge clk);
      i_argA  = 32'h8000_0000;
      i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
      repeat (4) @(negedge clk);
      i_rst = 1'b1;
      @(negedge clk);
      i_rst = 1'b0;
      chk_idle_zero("abort");
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (o_done) dones++;
      end
      chk("abort_nodone", 64'(dones), 64'd0);
      run_op(32'h0000_0004, 0, "after_abort");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_wyszukiwanie_bitu
